// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit driving HI/LO write enables
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             hi_wea,
  output logic             lo_wea
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int CW = $clog2(ITER + 1);
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   rs_q, rs_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rs_neg, rt_neg, start_ok, div_ok;
  logic [WIDTH-1:0]   rs_mag, rt_mag, quo_fix, rem_fix;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  always_comb begin
    rs_neg    = op[0] & rs_data[WIDTH-1];
    rt_neg    = op[0] & rt_data[WIDTH-1];
    rs_mag    = rs_neg ? -rs_data : rs_data;
    rt_mag    = rt_neg ? -rt_data : rt_data;
    start_ok  = start && (state_q == IDLE || state_q == DONE);
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_trial = {rem_q, acc_q[WIDTH-1]};
    div_ok    = div_trial >= {1'b0, b_q};
    prod_fix  = neg_q ? -acc_q : acc_q;
    quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = rneg_q ? -rem_q : rem_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    b_d       = b_q;
    rs_d      = rs_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    if (start_ok) begin
      state_d  = CALC;
      cnt_d    = '0;
      busy_d   = 1'b1;
      is_div_d = op[1];
      neg_d    = rs_neg ^ rt_neg;
      rneg_d   = rs_neg;
      dz_d     = rt_data == '0;
      rs_d     = rs_data;
      rem_d    = '0;
      b_d      = op[1] ? rt_mag : rs_mag;
      acc_d    = {{WIDTH{1'b0}}, op[1] ? rs_mag : rt_mag};
    end else if (state_q == CALC) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == CW'(ITER - 1)) ? FIX : CALC;
      if (is_div_q) begin
        rem_d = div_ok ? div_trial[WIDTH-1:0] - b_q : div_trial[WIDTH-1:0];
        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ok};
      end else begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
    end else if (state_q == FIX) begin
      state_d = DONE;
      done_d  = 1'b1;
      hi_d    = is_div_q ? (dz_q ? rs_q : rem_fix) : prod_fix[2*WIDTH-1:WIDTH];
      lo_d    = is_div_q ? (dz_q ? '1 : quo_fix) : prod_fix[WIDTH-1:0];
    end else if (state_q == DONE) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      b_q      <= '0;
      rs_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      b_q      <= b_d;
      rs_q     <= rs_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign hi_wea = done_q;
  assign lo_wea = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        busy, done, hi_wea, lo_wea;
  logic [31:0] hi_out, lo_out;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [1:0]  nx_op;
  logic [31:0] nx_a, nx_b;
  muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out), .hi_wea(hi_wea), .lo_wea(lo_wea)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint q, r;
    if (o == 2'b00) return {32'b0, a} * {32'b0, b};
    if (o == 2'b01) return sa * sb;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (o == 2'b10) return {a % b, a / b};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o;
    rs_data = a;
    rt_data = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom);
    rs_data = $urandom;
    rt_data = $urandom;
  endtask
  task automatic wait_done(input logic [63:0] exp, input string tag, input bit b2b, input bit glitch);
    int k;
    chk($sformatf("%s.busy_e1", tag), 64'(busy), 64'd1);
    for (k = 1; k <= 40; k++) begin
      if (glitch && k == 10) begin
        start = 1'b1;
        op = 2'b00;
        rs_data = 32'd7;
        rt_data = 32'd9;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) break;
    end
    chk($sformatf("%s.latency", tag), 64'(k), 64'd33);
    chk($sformatf("%s.result", tag), {hi_out, lo_out}, exp);
    chk($sformatf("%s.wea", tag), {62'd0, hi_wea, lo_wea}, 64'd3);
    chk($sformatf("%s.busy_e33", tag), 64'(busy), 64'd1);
    if (b2b) begin
      start = 1'b1;
      op = nx_op;
      rs_data = nx_a;
      rt_data = nx_b;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    chk($sformatf("%s.pulse_end", tag), {61'd0, done, hi_wea, lo_wea}, 64'd0);
    chk($sformatf("%s.busy_e34", tag), 64'(busy), 64'(b2b));
    chk($sformatf("%s.hold", tag), {hi_out, lo_out}, exp);
  endtask
  initial begin
    int p;
    logic [1:0] o;
    logic [31:0] a, b;
    @(posedge clk);
    #1;
    chk("reset.ctl", {60'd0, busy, done, hi_wea, lo_wea}, 64'd0);
    chk("reset.data", {hi_out, lo_out}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(2'b01, 32'hFFFFFFFD, 32'd5);
    wait_done({32'hFFFFFFFF, 32'hFFFFFFF1}, "mult_neg3x5", 1'b0, 1'b0);
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done({32'hFFFFFFFE, 32'h00000001}, "multu_max", 1'b0, 1'b0);
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done({32'h0, 32'h1}, "mult_m1m1", 1'b0, 1'b0);
    issue(2'b10, 32'd100, 32'd7);
    wait_done({32'd2, 32'd14}, "divu_100_7", 1'b0, 1'b0);
    issue(2'b11, 32'hFFFFFFF9, 32'd2);
    wait_done({32'hFFFFFFFF, 32'hFFFFFFFD}, "div_neg7_2", 1'b0, 1'b0);
    issue(2'b11, 32'h80000000, 32'hFFFFFFFF);
    wait_done({32'h0, 32'h80000000}, "div_ovf", 1'b0, 1'b0);
    issue(2'b10, 32'h12345678, 32'd0);
    wait_done({32'h12345678, 32'hFFFFFFFF}, "divu_by0", 1'b0, 1'b0);
    issue(2'b11, 32'h87654321, 32'd0);
    wait_done({32'h87654321, 32'hFFFFFFFF}, "div_by0", 1'b0, 1'b0);
    issue(2'b11, 32'd7, 32'hFFFFFFFE);
    wait_done({32'd1, 32'hFFFFFFFD}, "div_7_neg2", 1'b0, 1'b0);
    nx_op = 2'b10;
    nx_a = 32'd100;
    nx_b = 32'd7;
    issue(2'b00, 32'd3, 32'd4);
    wait_done({32'd0, 32'd12}, "multu_ignore_b2b", 1'b1, 1'b1);
    wait_done({32'd2, 32'd14}, "b2b_second", 1'b0, 1'b0);
    issue(2'b10, 32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort.ctl", {60'd0, busy, done, hi_wea, lo_wea}, 64'd0);
    chk("abort.data", {hi_out, lo_out}, 64'd0);
    p = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || hi_wea || lo_wea || busy) p++;
    end
    chk("abort.no_pulse", 64'(p), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    op = 2'b00;
    rs_data = 32'd3;
    rt_data = 32'd4;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_beats_start", 64'(busy), 64'd0);
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 9));
        3: a = 32'h80000000;
        default: ;
      endcase
      issue(o, a, b);
      wait_done(model(o, a, b), $sformatf("rand%0d_op%0d_%h_%h", i, o, a, b), 1'b0, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle multiply/divide unit that sits directly upstream of the HI and LO special registers. It executes MULT, MULTU, DIV and DIVU on rs/rt operands and produces a 64-bit result. It then drives one-cycle write enables so the HI and LO registers capture the result. The pipeline control stalls on busy.

Parameters:
WIDTH, 32, operand width; hi/lo result halves are WIDTH bits each
ITER, 32, number of iteration cycles (must equal WIDTH)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  2  00=MULTU, 01=MULT, 10=DIVU, 11=DIV
rs_data  input  32  multiplicand / dividend
rt_data  input  32  multiplier / divisor
busy  output  1  operation in progress; start ignored while high
done  output  1  one-cycle pulse when result is presented
hi_out  output  32  MULT*: product[63:32]; DIV*: remainder
lo_out  output  32  MULT*: product[31:0]; DIV*: quotient
hi_wea  output  1  write enable to HI register; equals done
lo_wea  output  1  write enable to LO register; equals done

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state=IDLE; busy=0, done=0, hi_wea=0, lo_wea=0, hi_out=0, lo_out=0; counter=0.
- States:
  - IDLE: if start=1 at edge E0, latch op and the operand magnitudes into internal registers. For signed ops, take the absolute value of each operand and record the result sign and the remainder sign. Go to CALC, counter=0, busy=1.
  - CALC: one iteration per cycle. Counter increments each cycle; after ITER iterations (edge E32), go to FIX.
    - Multiply: shift-add on a 64-bit accumulator.
    - Divide: restoring shift-subtract on a 33-bit partial remainder.
  - FIX: apply two's-complement negation where the recorded sign requires it. Register hi_out/lo_out. Assert done, hi_wea and lo_wea for exactly this one cycle (the cycle after E33). Go to IDLE at E34; busy=0 from E34.
- Latency: start at E0 -> write pulse visible E33–E34. Total 34 cycles; busy high E0–E34. A new start is accepted at E34 at the earliest (back-to-back).
- hi_out/lo_out hold their last result until the next FIX or reset.
- start while busy: ignored. Changes to rs_data/rt_data/op after E0 have no effect.
- Signed multiply: product sign = sign(rs) XOR sign(rt); negate the full 64-bit value.
- Signed divide:
  - Quotient sign = sign(rs) XOR sign(rt).
  - Remainder sign = sign(rs).
  - Magnitude of 0x80000000 handled as unsigned 0x80000000.
  - 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (two's-complement wrap, no trap).
- Divide by zero (rt=0, DIV or DIVU): same latency. lo=0xFFFFFFFF, hi=rs_data (original signed value). No exception.
- Reset mid-operation: at the rst edge, return to IDLE with outputs at reset values. No write pulse is issued for the aborted op.
- rst and start high together: rst wins.

Test Plan:
1. MULT rs=0xFFFFFFFD (-3), rt=5 -> at E33: done=1, hi_wea=lo_wea=1, hi_out=0xFFFFFFFF, lo_out=0xFFFFFFF1; busy low at E34.
2. MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi_out=0xFFFFFFFE, lo_out=0x00000001. MULT with the same operands -> hi_out=0, lo_out=1.
3. DIVU rs=100, rt=7 -> lo_out=0x0000000E, hi_out=0x00000002. DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
4. DIV rs=0x80000000, rt=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0. DIVU rs=0x12345678, rt=0 -> lo_out=0xFFFFFFFF, hi_out=0x12345678, still 34-cycle latency.
5. Start MULTU 3×4, then pulse start with different operands at E10 -> second request ignored, result hi=0, lo=12. Issue a new start in the done cycle's following edge (E34) -> accepted; busy stays high continuously.
6. Start DIVU 100/7, assert rst at E15 -> busy=0 and outputs zero after that edge; no done/wea pulse appears within 40 cycles.
